// File: rtl/path_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : path_entry_pkg
//  Purpose  : Shared types and constants for the path-entry controller:
//             debounce FSM state encoding, largest accepted digit and the
//             saturation limit of the strobe counter.
//  Revision : 1.0  initial release
// ============================================================================
package path_entry_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Largest code treated as a decimal digit when filtering is enabled
  localparam logic [3:0] MAX_DIGIT       = 4'd9;
  // entry_count stops here rather than wrapping
  localparam logic [2:0] ENTRY_COUNT_MAX = 3'd7;

  // True when the code is a decimal digit 0..9
  function automatic logic is_valid_digit(input logic [3:0] code);
    return (code <= MAX_DIGIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/path_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : path_entry_ctrl_if
//  Purpose  : Groups the raw operator inputs and the digit-strobe outputs of
//             the path-entry controller. The controller uses the slave view,
//             whoever drives the button/switches uses the master view.
//  Revision : 1.0  initial release
// ============================================================================
interface path_entry_ctrl_if;

  logic       btn_raw;       // bouncing "enter" button, 1 = pressed
  logic [3:0] sw_raw;        // path-digit switches, unsynchronized
  logic       insere;        // one-cycle strobe: new accepted digit
  logic [3:0] path_input;    // registered digit, valid while insere = 1
  logic       invalid_flag;  // one-cycle strobe: rejected code
  logic [2:0] entry_count;   // strobes since reset, saturating at 7

  modport master (
    output btn_raw, sw_raw,
    input  insere, path_input, invalid_flag, entry_count
  );

  modport slave (
    input  btn_raw, sw_raw,
    output insere, path_input, invalid_flag, entry_count
  );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchronizer, WIDTH bits wide, two cycles of latency.
//             Each bit is synchronized independently; multi-bit users must
//             tolerate bits settling on different cycles.
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // Next values of the two synchronizer stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer chain, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/path_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : path_entry_ctrl
//  Purpose  : Debounces the "enter" button and, once per debounced press,
//             captures the switch code and strobes it to the path checker.
//             Optional build macro DIGIT_FILTER_EN: codes above 9 raise
//             invalid_flag instead of insere and leave path_input and
//             entry_count untouched.
//  Revision : 1.0  initial release
// ============================================================================
module path_entry_ctrl
  import path_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  path_entry_ctrl_if.slave  bus
);

  localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic       btn_sync;
  logic [3:0] sw_sync;

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             insere_d, insere_q;
  logic             invalid_d, invalid_q;
  logic [3:0]       path_d, path_q;
  logic [2:0]       count_d, count_q;

  sync_2ff #(.WIDTH(1)) u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_raw),
    .q     (btn_sync)
  );

  sync_2ff #(.WIDTH(4)) u_sync_sw (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sw_raw),
    .q     (sw_sync)
  );

  // Debounce FSM next state; the press is accepted one cycle after the
  // counter has reached DEBOUNCE_CYCLES, which is where the switches are
  // sampled and the strobe is launched.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    insere_d  = 1'b0;
    invalid_d = 1'b0;
    path_d    = path_q;
    count_d   = count_q;

    case (state_q)
      ST_IDLE: begin
        if (btn_sync) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end

      ST_PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_TARGET) begin
          state_d = ST_HELD;
          cnt_d   = '0;
`ifdef DIGIT_FILTER_EN
          if (!is_valid_digit(sw_sync)) begin
            invalid_d = 1'b1;
          end else begin
            insere_d = 1'b1;
            path_d   = sw_sync;
            count_d  = (count_q == ENTRY_COUNT_MAX) ? count_q : count_q + 3'd1;
          end
`else
          insere_d = 1'b1;
          path_d   = sw_sync;
          count_d  = (count_q == ENTRY_COUNT_MAX) ? count_q : count_q + 3'd1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HELD: begin
        // A long hold never re-triggers; only a release leaves this state
        if (!btn_sync) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end

      ST_RELEASE_WAIT: begin
        if (btn_sync) begin
          // Release bounce: back to HELD without a new strobe
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_TARGET) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      insere_q  <= 1'b0;
      invalid_q <= 1'b0;
      path_q    <= 4'b0000;
      count_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      insere_q  <= insere_d;
      invalid_q <= invalid_d;
      path_q    <= path_d;
      count_q   <= count_d;
    end
  end

  assign bus.insere       = insere_q;
  assign bus.invalid_flag = invalid_q;
  assign bus.path_input   = path_q;
  assign bus.entry_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_path_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_path_entry_ctrl
//  Purpose  : Self-checking bench for path_entry_ctrl: a table of clean
//             presses plus hand-written bounce, hold, reset and filter cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_path_entry_ctrl;

  logic clk;
  logic reset;

  path_entry_ctrl_if bus ();

  path_entry_ctrl #(.DEBOUNCE_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    int         hold;
    logic [3:0] exp_path;
    logic [2:0] exp_count;
  } vec_t;

  vec_t vecs [8];

  int checks;
  int errors;

  // Observations gathered by watch()
  int ins_n, ins_first, inv_n, inv_first;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Run n clock cycles, sampling #1 after each rising edge. Cycle indices
  // count edges since the call, so a strobe first seen after edge 19
  // reports first = 19.
  task automatic watch(input int n);
    ins_n = 0; ins_first = -1; inv_n = 0; inv_first = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (bus.insere === 1'b1) begin
        ins_n++;
        if (ins_first < 0) ins_first = i;
      end
      if (bus.invalid_flag === 1'b1) begin
        inv_n++;
        if (inv_first < 0) inv_first = i;
      end
      check("strobe_exclusive", int'(bus.insere & bus.invalid_flag), 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{sw: 4'd5, hold: 40, exp_path: 4'd5, exp_count: 3'd1};
    vecs[1] = '{sw: 4'd9, hold: 25, exp_path: 4'd9, exp_count: 3'd2};
    vecs[2] = '{sw: 4'd0, hold: 25, exp_path: 4'd0, exp_count: 3'd3};
    vecs[3] = '{sw: 4'd0, hold: 25, exp_path: 4'd0, exp_count: 3'd4};
    vecs[4] = '{sw: 4'd6, hold: 25, exp_path: 4'd6, exp_count: 3'd5};
    vecs[5] = '{sw: 4'd0, hold: 25, exp_path: 4'd0, exp_count: 3'd6};
    vecs[6] = '{sw: 4'd3, hold: 25, exp_path: 4'd3, exp_count: 3'd7};
    vecs[7] = '{sw: 4'd1, hold: 25, exp_path: 4'd1, exp_count: 3'd7};

    reset       = 1'b1;
    bus.btn_raw = 1'b0;
    bus.sw_raw  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_insere",  int'(bus.insere),       0);
    check("reset_invalid", int'(bus.invalid_flag), 0);
    check("reset_path",    int'(bus.path_input),   0);
    check("reset_count",   int'(bus.entry_count),  0);
    reset = 1'b0;
    watch(5);

    // Eight clean presses; count saturates at 7
    for (int i = 0; i < 8; i++) begin
      bus.sw_raw  = vecs[i].sw;
      bus.btn_raw = 1'b1;
      watch(vecs[i].hold);
      check("press_strobes", ins_n,     1);
      check("press_latency", ins_first, 19);
      check("press_invalid", inv_n,     0);
      check("press_path",    int'(bus.path_input),  int'(vecs[i].exp_path));
      check("press_count",   int'(bus.entry_count), int'(vecs[i].exp_count));
      bus.btn_raw = 1'b0;
      watch(25);
      check("release_strobes", ins_n, 0);
    end

    // Asynchronous reset between edges clears everything at once
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_count", int'(bus.entry_count), 0);
    check("async_reset_path",  int'(bus.path_input),  0);
    check("async_reset_ins",   int'(bus.insere),      0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    watch(3);

    // Press shorter than the debounce window is ignored
    bus.sw_raw  = 4'd4;
    bus.btn_raw = 1'b1;
    watch(10);
    check("short_press_ins", ins_n, 0);
    bus.btn_raw = 1'b0;
    watch(25);
    check("short_release_ins", ins_n, 0);
    check("short_count", int'(bus.entry_count), 0);

    // Bouncing press: three toggles, then stable
    bus.sw_raw  = 4'd9;
    bus.btn_raw = 1'b1; watch(2); check("bounce_ins_a", ins_n, 0);
    bus.btn_raw = 1'b0; watch(2); check("bounce_ins_b", ins_n, 0);
    bus.btn_raw = 1'b1; watch(2); check("bounce_ins_c", ins_n, 0);
    bus.btn_raw = 1'b0; watch(2); check("bounce_ins_d", ins_n, 0);
    bus.btn_raw = 1'b1;
    watch(30);
    check("bounce_strobes", ins_n,     1);
    check("bounce_latency", ins_first, 19);
    check("bounce_path",    int'(bus.path_input),  9);
    check("bounce_count",   int'(bus.entry_count), 1);

    // Switch change while held does not move path_input
    bus.sw_raw = 4'd3;
    watch(10);
    check("held_sw_ins",  ins_n, 0);
    check("held_sw_path", int'(bus.path_input), 9);

    // Release bounce: brief drop then back, then final release
    bus.btn_raw = 1'b0; watch(5);  check("rel_bounce_drop", ins_n, 0);
    bus.btn_raw = 1'b1; watch(10); check("rel_bounce_back", ins_n, 0);
    bus.btn_raw = 1'b0; watch(25); check("rel_final", ins_n, 0);
    check("rel_count", int'(bus.entry_count), 1);

    // Reset in PRESS_WAIT at counter 10, button still held after release
    bus.sw_raw  = 4'd7;
    bus.btn_raw = 1'b1;
    watch(12);
    reset = 1'b1;
    #1;
    check("midpress_rst_count", int'(bus.entry_count), 0);
    watch(3);
    check("midpress_rst_ins", ins_n, 0);
    reset = 1'b0;
    watch(25);
    check("midpress_strobes", ins_n,     1);
    check("midpress_latency", ins_first, 19);
    check("midpress_path",    int'(bus.path_input),  7);
    check("midpress_count",   int'(bus.entry_count), 1);
    bus.btn_raw = 1'b0;
    watch(25);

    // Non-decimal code 12
    bus.sw_raw  = 4'd12;
    bus.btn_raw = 1'b1;
    watch(25);
`ifdef DIGIT_FILTER_EN
    check("code12_invalid_n",   inv_n,     1);
    check("code12_invalid_lat", inv_first, 19);
    check("code12_ins",         ins_n,     0);
    check("code12_path",        int'(bus.path_input),  7);
    check("code12_count",       int'(bus.entry_count), 1);
`else
    check("code12_ins_n",   ins_n,     1);
    check("code12_ins_lat", ins_first, 19);
    check("code12_invalid", inv_n,     0);
    check("code12_path",    int'(bus.path_input),  12);
    check("code12_count",   int'(bus.entry_count), 2);
`endif
    bus.btn_raw = 1'b0;
    watch(25);
    check("code12_release", ins_n + inv_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/path_entry_ctrl.md
PATH_ENTRY_CTRL -- requirements
Module: path_entry_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized cycles required to accept a level change (min 2).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port btn_raw  input  1  unsynchronized, bouncing "enter" push-button, 1 = pressed.
REQ-005 SHALL have port sw_raw  input  4  unsynchronized path-digit switches.
REQ-006 SHALL have port insere  output  1  one-cycle strobe marking a new accepted digit for the downstream path checker.
REQ-007 SHALL have port path_input  output  4  registered digit; valid whenever insere=1, held otherwise.
REQ-008 SHALL have port invalid_flag  output  1  one-cycle strobe for a rejected code (DIGIT_FILTER_EN only).
REQ-009 SHALL have port entry_count  output  3  number of strobes issued since reset, saturating at 7.

Function
REQ-010 SHALL pass btn_raw and sw_raw through two-flop synchronizers (2-cycle latency) before any use.
REQ-011 SHALL implement FSM IDLE, PRESS_WAIT, HELD, RELEASE_WAIT with a debounce counter of width $clog2(DEBOUNCE_CYCLES)+1.
REQ-012 IDLE: sync btn=1 -> PRESS_WAIT with counter=1; else stay.
REQ-013 PRESS_WAIT: sync btn=0 -> IDLE, counter cleared; btn=1 increments counter; on counter reaching DEBOUNCE_CYCLES -> HELD.
REQ-014 On the PRESS_WAIT->HELD transition SHALL sample synchronized sw into path_input and assert insere in the following cycle for exactly one cycle.
REQ-015 HELD: no further strobes regardless of duration; sync btn=0 -> RELEASE_WAIT, counter=1.
REQ-016 RELEASE_WAIT: btn=1 -> HELD (bounce, no strobe); btn=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
REQ-017 Latency: raw press stable from cycle 0 -> insere=1 at cycle 2+DEBOUNCE_CYCLES+1, exactly one pulse per debounced press.
REQ-018 Switch changes while not in PRESS_WAIT->HELD transition SHALL not alter path_input.
REQ-019 entry_count SHALL increment with each insere strobe and hold at 7 (no wrap).
REQ-020 insere and invalid_flag SHALL never be high in the same cycle.

Reset
REQ-021 Reset SHALL force FSM=IDLE, counter=0, synchronizer flops=0, insere=0, path_input=4'b0000, invalid_flag=0, entry_count=0, immediately and asynchronously.
REQ-022 Reset mid-press (any state) SHALL abort with no strobe; a button still held after reset release SHALL count as a new press and produce one strobe after full debounce.

Configuration
REQ-023 Macro DIGIT_FILTER_EN defined: sampled code >9 SHALL produce invalid_flag=1 for one cycle instead of insere; path_input and entry_count unchanged.
REQ-024 Macro DIGIT_FILTER_EN undefined: all codes 0-15 forwarded with insere; invalid_flag tied 0.

Structure
REQ-025 Package path_entry_pkg SHALL hold the FSM state enum, MAX_DIGIT=4'd9 and ENTRY_COUNT_MAX=3'd7.
REQ-026 Sub-module sync_2ff (parameter WIDTH) SHALL implement the synchronizers, instantiated once for btn (WIDTH=1) and once for sw (WIDTH=4).

Verification
REQ-027 Clean press, sw=4'd5, held 40 cycles, DEBOUNCE_CYCLES=16 -> one insere at cycle 19 after press, path_input=5, entry_count=1.
REQ-028 Bouncing press: 3 toggles within 10 cycles then stable -> exactly one insere, counted from last stable edge.
REQ-029 Release bounce: in HELD, btn drops for 5 cycles then returns -> no strobe; final release -> IDLE after 16 stable cycles.
REQ-030 Eight presses with sw=5,9,0,0,6,0,3,1 -> eight strobes with those values, entry_count saturates at 7.
REQ-031 DIGIT_FILTER_EN, press with sw=4'd12 -> invalid_flag one cycle, no insere, path_input keeps previous value.
REQ-032 Reset asserted in PRESS_WAIT at counter=10, button held after release -> no strobe during reset, one strobe 19 cycles after release, entry_count=1.
